// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: launches the shared mult/div units and commits HI/LO.
// Also raises the div-by-zero and timeout exceptions for the control FSM.
module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic op_valid,
    input  logic op_kind,
    output logic op_ready,
    input  logic flush,
    output logic mult_start,
    input  logic mult_done,
    output logic div_start,
    input  logic div_done,
    input  logic div_by_zero,
    output logic hi_write,
    output logic lo_write,
    output logic hilo_sel,
    output logic busy,
    output logic hilo_stall,
    output logic op_done,
    output logic exc_div0,
    output logic exc_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_COMMIT,
        S_DIV0,
        S_TOUT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic             kind_q;
    logic             kind_n;
    logic             done_sel;

    // Only the unit that was launched may finish the operation.
    assign done_sel = kind_q ? div_done : mult_done;

    // State, wait counter and operation kind registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kind_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            kind_q  <= kind_n;
        end
    end

    // Next-state logic; flush beats done and any pending request.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        kind_n  = kind_q;
        unique case (state_q)
            S_IDLE: begin
                if (op_valid && !flush) begin
                    kind_n  = op_kind;
                    state_n = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_n = '0;
                if (flush) state_n = S_IDLE;
                else       state_n = S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else if (done_sel) begin
                    if (kind_q && div_by_zero) state_n = S_DIV0;
                    else                       state_n = S_COMMIT;
                end else if (cnt_q == CNT_LAST) begin
                    state_n = S_TOUT;
                end else begin
                    cnt_n = cnt_q + CNT_ONE;
                end
            end
            S_COMMIT: state_n = S_IDLE;
            S_DIV0:   state_n = S_IDLE;
            S_TOUT:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Outputs decode registered state only, so no input reaches an output.
    always_comb begin
        op_ready    = 1'b0;
        mult_start  = 1'b0;
        div_start   = 1'b0;
        hi_write    = 1'b0;
        lo_write    = 1'b0;
        op_done     = 1'b0;
        exc_div0    = 1'b0;
        exc_timeout = 1'b0;
        unique case (state_q)
            S_IDLE:   op_ready = 1'b1;
            S_LAUNCH: begin
                mult_start = ~kind_q;
                div_start  = kind_q;
            end
            S_WAIT:   ;
            S_COMMIT: begin
                hi_write = 1'b1;
                lo_write = 1'b1;
                op_done  = 1'b1;
            end
            S_DIV0:   exc_div0    = 1'b1;
            S_TOUT:   exc_timeout = 1'b1;
            default:  ;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign hilo_stall = busy;
    assign hilo_sel   = kind_q;

endmodule
